// File: rtl/tile_vector_driver.sv
// tile_vector_driver: applies one test vector at a time to a Wokwi microtile.
// It drives the stimulus onto the tile's ui_in, waits SETTLE_CYCLES, samples
// uo_out, compares it under the mask and returns the result. Saturating
// pass/fail counters keep a running tally.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. vec_ready is 1 only in IDLE. rsp_valid stays 1 with rsp_data and
// rsp_mismatch held stable until an edge with rsp_ready=1. Neither valid
// depends combinationally on the opposite ready.
module tile_vector_driver #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [7:0]       vec_stim,
    input  logic [7:0]       vec_expect,
    input  logic [7:0]       vec_mask,
    output logic [7:0]       tile_ui_in,
    input  logic [7:0]       tile_uo_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_mismatch,
    input  logic             clr_counts,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    // The counter runs from SETTLE_CYCLES-1 down to 0, so the sample edge
    // lands exactly SETTLE_CYCLES edges after the accept edge.
    localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [7:0]       expect_q, expect_d;
    logic [7:0]       mask_q, mask_d;
    logic [7:0]       ui_q, ui_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_mis_q, rsp_mis_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             sample_mis;

    assign sample_mis = |((tile_uo_out ^ expect_q) & mask_q);

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        expect_d    = expect_q;
        mask_d      = mask_q;
        ui_d        = ui_q;
        rsp_data_d  = rsp_data_q;
        rsp_mis_d   = rsp_mis_q;
        rsp_valid_d = rsp_valid_q;
        pass_d      = pass_q;
        fail_d      = fail_q;
        vec_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                vec_ready = 1'b1;
                if (vec_valid) begin
                    ui_d     = vec_stim;
                    expect_d = vec_expect;
                    mask_d   = vec_mask;
                    cnt_d    = SETTLE_LOAD;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 8'd0) begin
                    rsp_data_d  = tile_uo_out;
                    rsp_mis_d   = sample_mis;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                    if (sample_mis) begin
                        if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
                    end else begin
                        if (pass_q != CNT_MAX) pass_d = pass_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase

        // A clear overrides any counter update on the same edge.
        if (clr_counts) begin
            pass_d = '0;
            fail_d = '0;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            expect_q    <= 8'd0;
            mask_q      <= 8'd0;
            ui_q        <= 8'd0;
            rsp_data_q  <= 8'd0;
            rsp_mis_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            expect_q    <= expect_d;
            mask_q      <= mask_d;
            ui_q        <= ui_d;
            rsp_data_q  <= rsp_data_d;
            rsp_mis_q   <= rsp_mis_d;
            rsp_valid_q <= rsp_valid_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
        end
    end

    assign tile_ui_in   = ui_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_mismatch = rsp_mis_q;
    assign pass_count   = pass_q;
    assign fail_count   = fail_q;
    assign busy         = (state_q != IDLE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_tile_vector_driver.sv
// Bench for tile_vector_driver. Three instances cover the default settle
// time (table + random vectors), SETTLE_CYCLES=1 with 2-bit counters
// (back-to-back and saturation) and SETTLE_CYCLES=8 (reset mid-settle).
module tb_tile_vector_driver;

  localparam int S_A = 4;
  localparam int S_B = 1;
  localparam int S_C = 8;

  int checks = 0;
  int failures = 0;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic c_rst_n = 1'b0;

  // instance A: SETTLE=4, CNT_W=16, tile uo_out = ui_in ^ a_xor
  logic a_vec_valid = 0, a_vec_ready, a_rsp_valid, a_rsp_ready = 0;
  logic [7:0] a_vec_stim = 0, a_vec_expect = 0, a_vec_mask = 0;
  logic [7:0] a_ui, a_uo, a_rsp_data, a_xor = 0;
  logic a_rsp_mis, a_clr = 0, a_busy;
  logic [15:0] a_pass, a_fail;
  logic [1:0] a_dbg;
  assign a_uo = a_ui ^ a_xor;

  tile_vector_driver #(.SETTLE_CYCLES(S_A), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .vec_valid(a_vec_valid), .vec_ready(a_vec_ready),
    .vec_stim(a_vec_stim), .vec_expect(a_vec_expect), .vec_mask(a_vec_mask),
    .tile_ui_in(a_ui), .tile_uo_out(a_uo), .rsp_valid(a_rsp_valid),
    .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_mismatch(a_rsp_mis),
    .clr_counts(a_clr), .pass_count(a_pass), .fail_count(a_fail),
    .busy(a_busy), .dbg_state(a_dbg));

  // instance B: SETTLE=1, CNT_W=2
  logic b_vec_valid = 0, b_vec_ready, b_rsp_valid, b_rsp_ready = 0;
  logic [7:0] b_vec_stim = 0, b_vec_expect = 0, b_vec_mask = 0;
  logic [7:0] b_ui, b_uo, b_rsp_data, b_xor = 0;
  logic b_rsp_mis, b_clr = 0, b_busy;
  logic [1:0] b_pass, b_fail, b_dbg;
  assign b_uo = b_ui ^ b_xor;

  tile_vector_driver #(.SETTLE_CYCLES(S_B), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .vec_valid(b_vec_valid), .vec_ready(b_vec_ready),
    .vec_stim(b_vec_stim), .vec_expect(b_vec_expect), .vec_mask(b_vec_mask),
    .tile_ui_in(b_ui), .tile_uo_out(b_uo), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_mismatch(b_rsp_mis),
    .clr_counts(b_clr), .pass_count(b_pass), .fail_count(b_fail),
    .busy(b_busy), .dbg_state(b_dbg));

  // instance C: SETTLE=8, CNT_W=16, identity tile, own reset
  logic c_vec_valid = 0, c_vec_ready, c_rsp_valid, c_rsp_ready = 1;
  logic [7:0] c_vec_stim = 0, c_vec_expect = 0, c_vec_mask = 0;
  logic [7:0] c_ui, c_rsp_data;
  logic c_rsp_mis, c_busy;
  logic [15:0] c_pass, c_fail;
  logic [1:0] c_dbg;

  tile_vector_driver #(.SETTLE_CYCLES(S_C), .CNT_W(16)) u_c (
    .clk(clk), .rst_n(c_rst_n), .vec_valid(c_vec_valid), .vec_ready(c_vec_ready),
    .vec_stim(c_vec_stim), .vec_expect(c_vec_expect), .vec_mask(c_vec_mask),
    .tile_ui_in(c_ui), .tile_uo_out(c_ui), .rsp_valid(c_rsp_valid),
    .rsp_ready(c_rsp_ready), .rsp_data(c_rsp_data), .rsp_mismatch(c_rsp_mis),
    .clr_counts(1'b0), .pass_count(c_pass), .fail_count(c_fail),
    .busy(c_busy), .dbg_state(c_dbg));

  // reference counters for instance A
  int pass_m = 0;
  int fail_m = 0;

  // scoreboard for instance B responses
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Driver + model for instance A. Called and returns at a negedge.
  task automatic run_a(input logic [7:0] stim, input logic [7:0] ev, input logic [7:0] mk,
                       input logic [7:0] xr, input int hold,
                       output logic [7:0] d_obs, output logic mis_obs);
    logic [7:0] m_data;
    logic m_mis;
    int n;
    m_data = stim ^ xr;
    m_mis = |((m_data ^ ev) & mk);
    a_xor = xr;
    a_vec_valid = 1; a_vec_stim = stim; a_vec_expect = ev; a_vec_mask = mk;
    chk("a_idle_vec_ready", {31'd0, a_vec_ready}, 1);
    @(posedge clk); @(negedge clk);
    a_vec_valid = 0; a_vec_stim = ~stim;
    chk("a_tile_ui_in", {24'd0, a_ui}, {24'd0, stim});
    chk("a_busy_settle", {31'd0, a_busy}, 1);
    n = 0;
    while (!a_rsp_valid && n < 300) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk("a_settle_latency", n, S_A);
    if (m_mis) begin if (fail_m < 65535) fail_m++; end
    else begin if (pass_m < 65535) pass_m++; end
    d_obs = a_rsp_data;
    mis_obs = a_rsp_mis;
    chk("a_rsp_data", {24'd0, a_rsp_data}, {24'd0, m_data});
    chk("a_rsp_mismatch", {31'd0, a_rsp_mis}, {31'd0, m_mis});
    chk("a_pass_count", {16'd0, a_pass}, pass_m);
    chk("a_fail_count", {16'd0, a_fail}, fail_m);
    for (int i = 0; i < hold; i++) begin
      a_vec_valid = 1; a_vec_stim = ~stim; a_vec_expect = $urandom; a_vec_mask = $urandom;
      @(posedge clk); @(negedge clk);
      chk("a_bp_vec_ready", {31'd0, a_vec_ready}, 0);
      chk("a_bp_rsp_valid", {31'd0, a_rsp_valid}, 1);
      chk("a_bp_rsp_data", {23'd0, a_rsp_mis, a_rsp_data}, {23'd0, m_mis, m_data});
      chk("a_bp_tile_ui_in", {24'd0, a_ui}, {24'd0, stim});
    end
    a_vec_valid = 0;
    a_rsp_ready = 1;
    @(posedge clk); @(negedge clk);
    a_rsp_ready = 0;
    chk("a_rsp_done_valid", {31'd0, a_rsp_valid}, 0);
    chk("a_rsp_done_busy", {31'd0, a_busy}, 0);
    chk("a_rsp_done_vec_ready", {31'd0, a_vec_ready}, 1);
    chk("a_ui_held", {24'd0, a_ui}, {24'd0, stim});
  endtask

  typedef struct {
    logic [7:0] stim;
    logic [7:0] ev;
    logic [7:0] mk;
    logic [7:0] xr;
    int         hold;
    logic [7:0] exp_data;
    logic       exp_mis;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] d_obs, s;
    logic mis_obs, seen_rsp;
    int sent, got, last_t, n;

    tbl[0] = '{8'hA5, 8'hA5, 8'hFF, 8'h00, 0,  8'hA5, 1'b0};
    tbl[1] = '{8'h0F, 8'h0F, 8'h01, 8'hFF, 0,  8'hF0, 1'b1};
    tbl[2] = '{8'h0F, 8'h0F, 8'h00, 8'hFF, 0,  8'hF0, 1'b0};
    tbl[3] = '{8'h3C, 8'h3C, 8'hFF, 8'h00, 10, 8'h3C, 1'b0};
    tbl[4] = '{8'h81, 8'h80, 8'hFE, 8'h00, 0,  8'h81, 1'b0};
    tbl[5] = '{8'h81, 8'h80, 8'h01, 8'h00, 2,  8'h81, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1; c_rst_n = 1;

    // reset state
    chk("rst_tile_ui_in", {24'd0, a_ui}, 0);
    chk("rst_rsp", {22'd0, a_rsp_valid, a_rsp_mis, a_rsp_data}, 0);
    chk("rst_counts", {a_pass, a_fail}, 0);
    chk("rst_vec_ready_busy", {30'd0, a_vec_ready, a_busy}, 32'd2);

    // table-driven vectors
    foreach (tbl[i]) begin
      run_a(tbl[i].stim, tbl[i].ev, tbl[i].mk, tbl[i].xr, tbl[i].hold, d_obs, mis_obs);
      chk("tbl_data", {24'd0, d_obs}, {24'd0, tbl[i].exp_data});
      chk("tbl_mis", {31'd0, mis_obs}, {31'd0, tbl[i].exp_mis});
    end

    // random vectors against the model
    for (int i = 0; i < 40; i++) begin
      run_a(8'($urandom), 8'($urandom), 8'($urandom_range(0, 255)),
            (i % 3 == 0) ? 8'h00 : 8'($urandom), $urandom_range(0, 3), d_obs, mis_obs);
    end

    // clear while idle
    a_clr = 1;
    @(posedge clk); @(negedge clk);
    a_clr = 0;
    pass_m = 0; fail_m = 0;
    chk("a_clr_counts", {a_pass, a_fail}, 0);

    // B: back-to-back with rsp_ready tied high, 5 matching vectors
    b_rsp_ready = 1;
    sent = 0; got = 0; last_t = -1;
    for (int t = 0; t < 40; t++) begin
      if (b_rsp_valid) begin
        if (exp_q.size() > 0) chk("b_rsp_data", {24'd0, b_rsp_data}, {24'd0, exp_q.pop_front()});
        else chk("b_extra_rsp", 1, 0);
        chk("b_rsp_mis", {31'd0, b_rsp_mis}, 0);
        if (last_t >= 0) chk("b_spacing", t - last_t, 3);
        last_t = t;
        got++;
      end
      if (b_vec_ready && sent < 5) begin
        s = 8'($urandom);
        b_vec_valid = 1; b_vec_stim = s; b_vec_expect = s; b_vec_mask = 8'($urandom);
        exp_q.push_back(s);
        sent++;
      end else begin
        b_vec_valid = 0;
      end
      @(posedge clk); @(negedge clk);
    end
    chk("b_rsp_total", got, 5);
    chk("b_pass_sat", {30'd0, b_pass}, 3);
    chk("b_fail_zero", {30'd0, b_fail}, 0);

    // B: clear on the same edge as a mismatch update
    b_xor = 8'hFF;
    b_vec_valid = 1; b_vec_stim = 8'h11; b_vec_expect = 8'h11; b_vec_mask = 8'hFF;
    @(posedge clk); @(negedge clk);
    b_vec_valid = 0; b_clr = 1;
    @(posedge clk); @(negedge clk);
    b_clr = 0;
    chk("b_clr_rsp_valid", {31'd0, b_rsp_valid}, 1);
    chk("b_clr_rsp", {23'd0, b_rsp_mis, b_rsp_data}, {23'd0, 1'b1, 8'hEE});
    chk("b_clr_counts", {28'd0, b_pass, b_fail}, 0);
    @(posedge clk); @(negedge clk);
    chk("b_clr_idle", {31'd0, b_busy}, 0);

    // C: complete one vector, then reset three cycles into SETTLE
    c_vec_valid = 1; c_vec_stim = 8'h5A; c_vec_expect = 8'h5A; c_vec_mask = 8'hFF;
    @(posedge clk); @(negedge clk);
    c_vec_valid = 0;
    n = 0;
    while (!c_rsp_valid && n < 50) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    chk("c_latency", n, S_C);
    @(posedge clk); @(negedge clk);
    chk("c_pass_one", {16'd0, c_pass}, 1);
    c_vec_valid = 1; c_vec_stim = 8'hC3; c_vec_expect = 8'h00; c_vec_mask = 8'hFF;
    @(posedge clk); @(negedge clk);
    c_vec_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("c_busy_pre_reset", {31'd0, c_busy}, 1);
    c_rst_n = 0;
    @(posedge clk); @(negedge clk);
    c_rst_n = 1;
    chk("c_rst_ui", {24'd0, c_ui}, 0);
    chk("c_rst_busy_ready", {30'd0, c_busy, c_vec_ready}, 1);
    chk("c_rst_counts", {c_pass, c_fail}, 0);
    seen_rsp = 0;
    for (int t = 0; t < 16; t++) begin
      if (c_rsp_valid) seen_rsp = 1;
      @(posedge clk); @(negedge clk);
    end
    chk("c_no_rsp_after_reset", {31'd0, seen_rsp}, 0);
    chk("c_counts_after", {c_pass, c_fail}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_vector_driver.md
Name: tile_vector_driver

Overview:
- Bench-side and bring-up counterpart to a Wokwi microtile, which only takes ui_in and gives back uo_out.
- It takes test vectors (stimulus, expected, mask) over a valid/ready handshake and drives the stimulus onto the tile's ui_in.
- It waits a fixed settle time, samples the tile's uo_out, compares it against the masked expectation, and returns the result over a second valid/ready handshake.
- It keeps saturating pass and fail counters, so tiles can be exercised from a controller or a bench without any tile-specific logic.

Parameters:
- SETTLE_CYCLES, 4, cycles between driving the stimulus and sampling uo_out. Legal range is 1 to 255.
- CNT_W, 16, width of the pass and fail counters.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  synchronous reset, active-low.
- vec_valid  in  1  a vector is offered.
- vec_ready  out  1  block accepts a vector this cycle.
- vec_stim  in  8  stimulus byte for tile ui_in.
- vec_expect  in  8  expected tile uo_out.
- vec_mask  in  8  compare mask; 1 = bit is checked.
- tile_ui_in  out  8  registered drive to the tile's ui_in.
- tile_uo_out  in  8  the tile's uo_out; combinational from the tile, treated as stable at the sample edge.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  8  captured uo_out.
- rsp_mismatch  out  1  1 if any masked bit differs.
- clr_counts  in  1  synchronous clear of both counters.
- pass_count  out  CNT_W  count of vectors that matched.
- fail_count  out  CNT_W  count of vectors that mismatched.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state goes to IDLE.
  - tile_ui_in, rsp_data, rsp_mismatch, rsp_valid, pass_count and fail_count all go to 0.
  - Reset mid-vector or mid-response abandons it; no counter update and no response.
- State machine: IDLE -> SETTLE -> RESP -> IDLE.
- IDLE:
  - vec_ready=1, busy=0.
  - On edge N with vec_valid=1: tile_ui_in<=vec_stim, and vec_expect/vec_mask are latched internally.
  - The settle counter is loaded with SETTLE_CYCLES-1 and the state goes to SETTLE.
- SETTLE:
  - vec_ready=0; the counter decrements once per cycle.
  - On the edge where the counter==0 (edge N+SETTLE_CYCLES):
    - rsp_data<=tile_uo_out.
    - rsp_mismatch<=|((tile_uo_out^expect)&mask).
    - fail_count increments if mismatched, otherwise pass_count increments.
    - rsp_valid<=1 and the state goes to RESP.
  - With SETTLE_CYCLES=1 the sample is taken at edge N+1.
- RESP:
  - rsp_valid=1, with rsp_data and rsp_mismatch held stable; vec_ready=0.
  - On an edge with rsp_ready=1: rsp_valid<=0 and the state goes to IDLE.
  - The earliest next vector acceptance is the following edge, so the per-vector cost is at least SETTLE_CYCLES+2 cycles.
- tile_ui_in holds the last stimulus indefinitely; it is never returned to 0 except by reset.
- Counters saturate at all-ones and never wrap.
- clr_counts=1 zeroes both counters on that edge.
  - If clr_counts coincides with a counter update, the clear wins and that update is lost.
  - clr_counts does not affect the state machine or the response.
- vec_* inputs are ignored outside IDLE, and rsp_ready is ignored outside RESP.
- A mask of 0x00 always reports a match, and pass_count increments.

Test Plan:
- Reset, then idle: all outputs are 0 and vec_ready=1. Push stim=0xA5, expect=0xA5, mask=0xFF with a tile model where uo_out=ui_in, accepted at edge N:
  - tile_ui_in=0xA5 after edge N.
  - rsp_valid rises at edge N+4 with rsp_data=0xA5 and rsp_mismatch=0.
  - pass_count=1, busy=1 until the response handshake completes.
- Tile model uo_out=~ui_in, with stim=0x0F, expect=0x0F, mask=0x01 -> rsp_data=0xF0, rsp_mismatch=1, fail_count=1. Repeat with mask=0x00 -> mismatch=0 and pass_count increments.
- Backpressure: hold rsp_ready=0 for 10 cycles while vec_valid=1 with a new vector:
  - vec_ready stays 0 and the response stays stable.
  - After rsp_ready=1, the new vector is accepted one edge after the handshake.
- Synthesize or simulate with CNT_W=2 and drive 5 matching vectors -> pass_count saturates at 3. Then pulse clr_counts in the same cycle as a mismatch update -> both counters read 0.
- Assert rst_n=0 during SETTLE (SETTLE_CYCLES=8, at cycle 3) -> state is IDLE, tile_ui_in=0, no rsp_valid pulse, and counters are 0.
- SETTLE_CYCLES=1 with back-to-back vectors and rsp_ready tied high -> each vector accepts, samples and responds every 3 cycles, with correct per-vector data.
